csi2_stat_acc_mc: RTL and testbench

- Multi-channel statistics accumulator for the CSI-2 receive path. Successor to the single-stream accumulator.
- Passively monitors CH_CNT pixel streams, one per virtual channel, at the AXI4-Stream handshake level.
- Keeps saturating error counters, per-channel frame counters, and min/max lines-per-frame and pixels-per-line.
- Sits between the receiver's output streams and the CSR block; outputs are read by the CSR block.

---
 rtl/csi2_stat_pkg.sv | 35 +++
 rtl/csi2_stat_ch.sv | 153 +++++++++++++++
 rtl/csi2_stat_acc_mc.sv | 75 +++++++
 tb/tb_csi2_stat_acc_mc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_stat_pkg.sv
// Shared types and helpers for the CSI-2 multi-channel statistics accumulator.
// Counter helpers work on values up to MAX_W bits wide. Narrower counters are
// widened on the way in and truncated on the way out.
package csi2_stat_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } ch_state_t;

    // All-ones value of a w-bit counter, right-aligned in MAX_W bits.
    function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
        logic [MAX_W:0] lim;
        lim = (33'd1 << w) - 33'd1;
        return lim[MAX_W-1:0];
    endfunction

    // Increment that sticks at the w-bit all-ones value instead of wrapping.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int unsigned w);
        return (v == all_ones(w)) ? v : v + 32'd1;
    endfunction

    // A minimum tracker starts high so the first sample always replaces it.
    function automatic logic [MAX_W-1:0] min_init(input int unsigned w);
        return all_ones(w);
    endfunction

    // A maximum tracker starts at zero so the first sample always replaces it.
    function automatic logic [MAX_W-1:0] max_init(input int unsigned w);
        return (w == 0) ? '0 : '0;
    endfunction

endpackage

// File: rtl/csi2_stat_ch.sv
// One monitored video channel: frame/line FSM, running pixel and line counts,
// min/max line length, min/max lines per frame, frame counter and stat_valid.
module csi2_stat_ch
    import csi2_stat_pkg::*;
#(
    parameter int unsigned PX_W      = 16,
    parameter int unsigned LN_W      = 16,
    parameter int unsigned FRM_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 beat,
    input  logic                 sof,
    input  logic                 eol,
    output logic [FRM_CNT_W-1:0] frame_cnt,
    output logic [LN_W-1:0]      max_ln,
    output logic [LN_W-1:0]      min_ln,
    output logic [PX_W-1:0]      max_px,
    output logic [PX_W-1:0]      min_px,
    output logic                 stat_valid
);

    localparam logic [PX_W-1:0] PX_MIN_INIT = PX_W'(min_init(PX_W));
    localparam logic [PX_W-1:0] PX_MAX_INIT = PX_W'(max_init(PX_W));
    localparam logic [LN_W-1:0] LN_MIN_INIT = LN_W'(min_init(LN_W));
    localparam logic [LN_W-1:0] LN_MAX_INIT = LN_W'(max_init(LN_W));

    function automatic logic [PX_W-1:0] inc_px(input logic [PX_W-1:0] v);
        return PX_W'(sat_inc(MAX_W'(v), PX_W));
    endfunction

    function automatic logic [LN_W-1:0] inc_ln(input logic [LN_W-1:0] v);
        return LN_W'(sat_inc(MAX_W'(v), LN_W));
    endfunction

    function automatic logic [FRM_CNT_W-1:0] inc_frm(input logic [FRM_CNT_W-1:0] v);
        return FRM_CNT_W'(sat_inc(MAX_W'(v), FRM_CNT_W));
    endfunction

    ch_state_t            state, state_nxt;
    logic [PX_W-1:0]      px_cnt, px_nxt;
    logic [LN_W-1:0]      ln_cnt, ln_nxt;
    logic [FRM_CNT_W-1:0] frame_nxt;
    logic [LN_W-1:0]      max_ln_nxt, min_ln_nxt;
    logic [PX_W-1:0]      max_px_nxt, min_px_nxt;
    logic                 stat_valid_nxt;
    logic                 start_frame, line_done, frame_done;
    logic [PX_W-1:0]      line_len;
    logic [LN_W-1:0]      frame_lines;

    // State and statistics registers; reset forces the clear values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_SOF;
            px_cnt     <= '0;
            ln_cnt     <= '0;
            frame_cnt  <= '0;
            max_ln     <= LN_MAX_INIT;
            min_ln     <= LN_MIN_INIT;
            max_px     <= PX_MAX_INIT;
            min_px     <= PX_MIN_INIT;
            stat_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            px_cnt     <= px_nxt;
            ln_cnt     <= ln_nxt;
            frame_cnt  <= frame_nxt;
            max_ln     <= max_ln_nxt;
            min_ln     <= min_ln_nxt;
            max_px     <= max_px_nxt;
            min_px     <= min_px_nxt;
            stat_valid <= stat_valid_nxt;
        end
    end

    // Next state: an SOF beat closes the old frame before the beat itself is
    // counted as the first pixel of the new one, so an SOF+EOL beat both
    // publishes the old line count and records a 1-pixel line.
    always_comb begin
        state_nxt      = state;
        px_nxt         = px_cnt;
        ln_nxt         = ln_cnt;
        frame_nxt      = frame_cnt;
        max_ln_nxt     = max_ln;
        min_ln_nxt     = min_ln;
        max_px_nxt     = max_px;
        min_px_nxt     = min_px;
        stat_valid_nxt = stat_valid;
        start_frame    = 1'b0;
        line_done      = 1'b0;
        frame_done     = 1'b0;
        line_len       = '0;
        frame_lines    = '0;

        if (clear) begin
            state_nxt      = WAIT_SOF;
            px_nxt         = '0;
            ln_nxt         = '0;
            frame_nxt      = '0;
            max_ln_nxt     = LN_MAX_INIT;
            min_ln_nxt     = LN_MIN_INIT;
            max_px_nxt     = PX_MAX_INIT;
            min_px_nxt     = PX_MIN_INIT;
            stat_valid_nxt = 1'b0;
        end else if (beat) begin
            unique case (state)
                WAIT_SOF: start_frame = sof;
                IN_FRAME: begin
                    if (sof) begin
                        frame_done  = 1'b1;
                        start_frame = 1'b1;
                        frame_lines = (px_cnt != '0) ? inc_ln(ln_cnt) : ln_cnt;
                    end else if (eol) begin
                        line_done = 1'b1;
                        line_len  = inc_px(px_cnt);
                        px_nxt    = '0;
                        ln_nxt    = inc_ln(ln_cnt);
                    end else begin
                        px_nxt = inc_px(px_cnt);
                    end
                end
                default: start_frame = 1'b0;
            endcase

            if (start_frame) begin
                state_nxt = IN_FRAME;
                if (eol) begin
                    line_done = 1'b1;
                    line_len  = PX_W'(1);
                    px_nxt    = '0;
                    ln_nxt    = LN_W'(1);
                end else begin
                    px_nxt = PX_W'(1);
                    ln_nxt = '0;
                end
            end

            if (frame_done) begin
                frame_nxt      = inc_frm(frame_cnt);
                stat_valid_nxt = 1'b1;
                if (frame_lines > max_ln) max_ln_nxt = frame_lines;
                if (frame_lines < min_ln) min_ln_nxt = frame_lines;
            end

            if (line_done) begin
                if (line_len > max_px) max_px_nxt = line_len;
                if (line_len < min_px) min_px_nxt = line_len;
            end
        end
    end

endmodule

// File: rtl/csi2_stat_acc_mc.sv
// Multi-channel CSI-2 receive statistics: three shared saturating error
// counters plus one csi2_stat_ch per virtual channel, packed onto flat buses.
module csi2_stat_acc_mc
    import csi2_stat_pkg::*;
#(
    parameter int unsigned CH_CNT    = 2,
    parameter int unsigned ERR_CNT_W = 32,
    parameter int unsigned FRM_CNT_W = 32,
    parameter int unsigned PX_W      = 16,
    parameter int unsigned LN_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        clear_stat_i,
    input  logic [CH_CNT-1:0]           tvalid_i,
    input  logic [CH_CNT-1:0]           tready_i,
    input  logic [CH_CNT-1:0]           tuser_i,
    input  logic [CH_CNT-1:0]           tlast_i,
    input  logic                        header_err_i,
    input  logic                        corr_header_err_i,
    input  logic                        crc_err_i,
    output logic [ERR_CNT_W-1:0]        header_err_cnt_o,
    output logic [ERR_CNT_W-1:0]        corr_header_err_cnt_o,
    output logic [ERR_CNT_W-1:0]        crc_err_cnt_o,
    output logic [CH_CNT*FRM_CNT_W-1:0] frame_cnt_o,
    output logic [CH_CNT*LN_W-1:0]      max_ln_per_frame_o,
    output logic [CH_CNT*LN_W-1:0]      min_ln_per_frame_o,
    output logic [CH_CNT*PX_W-1:0]      max_px_per_ln_o,
    output logic [CH_CNT*PX_W-1:0]      min_px_per_ln_o,
    output logic [CH_CNT-1:0]           stat_valid_o
);

    function automatic logic [ERR_CNT_W-1:0] inc_err(input logic [ERR_CNT_W-1:0] v);
        return ERR_CNT_W'(sat_inc(MAX_W'(v), ERR_CNT_W));
    endfunction

    // Error counters are channel-independent; a clear wins over any same-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            header_err_cnt_o      <= '0;
            corr_header_err_cnt_o <= '0;
            crc_err_cnt_o         <= '0;
        end else if (clear_stat_i) begin
            header_err_cnt_o      <= '0;
            corr_header_err_cnt_o <= '0;
            crc_err_cnt_o         <= '0;
        end else begin
            if (header_err_i)      header_err_cnt_o      <= inc_err(header_err_cnt_o);
            if (corr_header_err_i) corr_header_err_cnt_o <= inc_err(corr_header_err_cnt_o);
            if (crc_err_i)         crc_err_cnt_o         <= inc_err(crc_err_cnt_o);
        end
    end

    for (genvar k = 0; k < CH_CNT; k++) begin : g_ch
        csi2_stat_ch #(
            .PX_W      (PX_W),
            .LN_W      (LN_W),
            .FRM_CNT_W (FRM_CNT_W)
        ) u_ch (
            .clk        (clk_i),
            .rst_n      (rst_n_i),
            .clear      (clear_stat_i),
            .beat       (tvalid_i[k] & tready_i[k]),
            .sof        (tuser_i[k]),
            .eol        (tlast_i[k]),
            .frame_cnt  (frame_cnt_o[k*FRM_CNT_W +: FRM_CNT_W]),
            .max_ln     (max_ln_per_frame_o[k*LN_W +: LN_W]),
            .min_ln     (min_ln_per_frame_o[k*LN_W +: LN_W]),
            .max_px     (max_px_per_ln_o[k*PX_W +: PX_W]),
            .min_px     (min_px_per_ln_o[k*PX_W +: PX_W]),
            .stat_valid (stat_valid_o[k])
        );
    end

endmodule

// File: tb/tb_csi2_stat_acc_mc.sv
// Directed bench for csi2_stat_acc_mc: a two-channel instance with default
// widths and a one-channel instance with 3-bit error counters for saturation.
module tb_csi2_stat_acc_mc;

    typedef struct packed {
        logic [1:0] tvalid;
        logic [1:0] tready;
        logic [1:0] tuser;
        logic [1:0] tlast;
        logic       hdr;
        logic       corr;
        logic       crc;
        logic       clr;
    } stim_t;

    typedef struct {
        logic        hdr;
        logic        corr;
        logic        crc;
        logic [31:0] exp_hdr;
        logic [31:0] exp_corr;
        logic [31:0] exp_crc;
    } err_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_stat = 1'b0;
    logic [1:0]  tvalid = '0, tready = '0, tuser = '0, tlast = '0;
    logic        header_err = 1'b0, corr_err = 1'b0, crc_err = 1'b0;

    logic [31:0] hdr_cnt, corr_cnt, crc_cnt;
    logic [63:0] frame_cnt;
    logic [31:0] max_ln, min_ln, max_px, min_px;
    logic [1:0]  stat_valid;

    logic [2:0]  hdr3, corr3, crc3;
    logic [31:0] frame3;
    logic [15:0] max_ln3, min_ln3, max_px3, min_px3;
    logic        stat_valid3;

    logic [31:0] frame_ch[2], max_ln_ch[2], min_ln_ch[2], max_px_ch[2], min_px_ch[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csi2_stat_acc_mc #(.CH_CNT(2), .ERR_CNT_W(32), .FRM_CNT_W(32), .PX_W(16), .LN_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_stat_i(clear_stat),
        .tvalid_i(tvalid), .tready_i(tready), .tuser_i(tuser), .tlast_i(tlast),
        .header_err_i(header_err), .corr_header_err_i(corr_err), .crc_err_i(crc_err),
        .header_err_cnt_o(hdr_cnt), .corr_header_err_cnt_o(corr_cnt), .crc_err_cnt_o(crc_cnt),
        .frame_cnt_o(frame_cnt), .max_ln_per_frame_o(max_ln), .min_ln_per_frame_o(min_ln),
        .max_px_per_ln_o(max_px), .min_px_per_ln_o(min_px), .stat_valid_o(stat_valid)
    );

    csi2_stat_acc_mc #(.CH_CNT(1), .ERR_CNT_W(3), .FRM_CNT_W(32), .PX_W(16), .LN_W(16)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_stat_i(clear_stat),
        .tvalid_i(tvalid[0:0]), .tready_i(tready[0:0]), .tuser_i(tuser[0:0]), .tlast_i(tlast[0:0]),
        .header_err_i(header_err), .corr_header_err_i(corr_err), .crc_err_i(crc_err),
        .header_err_cnt_o(hdr3), .corr_header_err_cnt_o(corr3), .crc_err_cnt_o(crc3),
        .frame_cnt_o(frame3), .max_ln_per_frame_o(max_ln3), .min_ln_per_frame_o(min_ln3),
        .max_px_per_ln_o(max_px3), .min_px_per_ln_o(min_px3), .stat_valid_o(stat_valid3)
    );

    for (genvar k = 0; k < 2; k++) begin : g_unpack
        assign frame_ch[k]  = frame_cnt[k*32 +: 32];
        assign max_ln_ch[k] = 32'(max_ln[k*16 +: 16]);
        assign min_ln_ch[k] = 32'(min_ln[k*16 +: 16]);
        assign max_px_ch[k] = 32'(max_px[k*16 +: 16]);
        assign min_px_ch[k] = 32'(min_px[k*16 +: 16]);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sample point is 1 time unit after the edge.
    task automatic applyStimulus(input stim_t s);
        tvalid     = s.tvalid;
        tready     = s.tready;
        tuser      = s.tuser;
        tlast      = s.tlast;
        header_err = s.hdr;
        corr_err   = s.corr;
        crc_err    = s.crc;
        clear_stat = s.clr;
        @(posedge clk);
        #1;
        tvalid = '0; tready = '0; tuser = '0; tlast = '0;
        header_err = 1'b0; corr_err = 1'b0; crc_err = 1'b0; clear_stat = 1'b0;
    endtask

    task automatic beat(input int ch, input bit user, input bit last);
        stim_t s = '0;
        s.tvalid[ch] = 1'b1;
        s.tready[ch] = 1'b1;
        s.tuser[ch]  = user;
        s.tlast[ch]  = last;
        applyStimulus(s);
    endtask

    // Non-beats that carry SOF/EOL flags; they must change nothing.
    task automatic noise(input int ch);
        stim_t s = '0;
        s.tvalid[ch] = 1'b1; s.tuser[ch] = 1'b1; s.tlast[ch] = 1'b1;
        applyStimulus(s);
        s = '0;
        s.tready[ch] = 1'b1; s.tuser[ch] = 1'b1; s.tlast[ch] = 1'b1;
        applyStimulus(s);
    endtask

    task automatic send_line(input int ch, input int px, input bit sof_first);
        for (int p = 0; p < px; p++) beat(ch, sof_first && (p == 0), p == px - 1);
    endtask

    // Full frame of lines x px, skipping the first 'first' beats.
    task automatic send_frame(input int ch, input int lines, input int px, input int first);
        for (int l = 0; l < lines; l++)
            for (int p = 0; p < px; p++)
                if (l * px + p >= first) beat(ch, (l == 0) && (p == 0), p == px - 1);
    endtask

    task automatic check_ch_clear(input int ch, input string tag);
        checkOutput({tag, " frame_cnt"}, frame_ch[ch], 32'd0);
        checkOutput({tag, " max_ln"}, max_ln_ch[ch], 32'd0);
        checkOutput({tag, " min_ln"}, min_ln_ch[ch], 32'hffff);
        checkOutput({tag, " max_px"}, max_px_ch[ch], 32'd0);
        checkOutput({tag, " min_px"}, min_px_ch[ch], 32'hffff);
    endtask

    task automatic pulse_hdr();
        stim_t s = '0;
        s.hdr = 1'b1;
        applyStimulus(s);
    endtask

    err_vec_t err_tbl[7];

    initial begin
        err_tbl[0] = '{1'b1, 1'b0, 1'b1, 32'd1, 32'd0, 32'd1};
        err_tbl[1] = '{1'b1, 1'b0, 1'b0, 32'd2, 32'd0, 32'd1};
        err_tbl[2] = '{1'b0, 1'b1, 1'b0, 32'd2, 32'd1, 32'd1};
        err_tbl[3] = '{1'b1, 1'b1, 1'b1, 32'd3, 32'd2, 32'd2};
        err_tbl[4] = '{1'b0, 1'b0, 1'b0, 32'd3, 32'd2, 32'd2};
        err_tbl[5] = '{1'b1, 1'b0, 1'b0, 32'd4, 32'd2, 32'd2};
        err_tbl[6] = '{1'b1, 1'b0, 1'b0, 32'd5, 32'd2, 32'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hdr_cnt", hdr_cnt, 32'd0);
        checkOutput("reset crc_cnt", crc_cnt, 32'd0);
        checkOutput("reset stat_valid", 32'(stat_valid), 32'd0);
        check_ch_clear(0, "reset ch0");
        check_ch_clear(1, "reset ch1");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Channel 0: three 4x8 frames; only the first two are closed
        send_frame(0, 4, 8, 0);
        checkOutput("ch0 trailing frame not counted", frame_ch[0], 32'd0);
        checkOutput("ch0 max_ln before SOF", max_ln_ch[0], 32'd0);
        checkOutput("ch0 max_px after 1st frame", max_px_ch[0], 32'd8);
        beat(0, 1'b1, 1'b0);
        checkOutput("ch0 frame_cnt after 2nd SOF", frame_ch[0], 32'd1);
        checkOutput("ch0 stat_valid after 2nd SOF", 32'(stat_valid), 32'd1);
        checkOutput("ch0 max_ln after 2nd SOF", max_ln_ch[0], 32'd4);
        send_frame(0, 4, 8, 1);
        beat(0, 1'b1, 1'b0);
        send_frame(0, 4, 8, 1);
        checkOutput("ch0 frame_cnt", frame_ch[0], 32'd2);
        checkOutput("ch0 min_px", min_px_ch[0], 32'd8);
        checkOutput("ch0 max_px", max_px_ch[0], 32'd8);
        checkOutput("ch0 min_ln", min_ln_ch[0], 32'd4);
        checkOutput("ch0 max_ln", max_ln_ch[0], 32'd4);
        checkOutput("ch0 stat_valid", 32'(stat_valid), 32'd1);
        check_ch_clear(1, "ch1 untouched");

        // Channel 1: lines of 5, 9, 3 px with stalls and idle cycles
        beat(1, 1'b1, 1'b0);
        noise(1);
        beat(1, 1'b0, 1'b0);
        noise(1);
        beat(1, 1'b0, 1'b0);
        beat(1, 1'b0, 1'b0);
        beat(1, 1'b0, 1'b1);
        for (int p = 0; p < 8; p++) begin
            beat(1, 1'b0, 1'b0);
            if (p == 3) noise(1);
        end
        beat(1, 1'b0, 1'b1);
        send_line(1, 3, 1'b0);
        beat(1, 1'b1, 1'b0);
        checkOutput("ch1 min_px", min_px_ch[1], 32'd3);
        checkOutput("ch1 max_px", max_px_ch[1], 32'd9);
        checkOutput("ch1 min_ln", min_ln_ch[1], 32'd3);
        checkOutput("ch1 max_ln", max_ln_ch[1], 32'd3);
        checkOutput("ch1 frame_cnt", frame_ch[1], 32'd1);
        checkOutput("both stat_valid", 32'(stat_valid), 32'd3);
        checkOutput("ch0 unaffected by ch1", frame_ch[0], 32'd2);

        // Error counters, table-driven
        for (int i = 0; i < 7; i++) begin
            stim_t s = '0;
            s.hdr  = err_tbl[i].hdr;
            s.corr = err_tbl[i].corr;
            s.crc  = err_tbl[i].crc;
            applyStimulus(s);
            checkOutput($sformatf("err vec %0d hdr", i), hdr_cnt, err_tbl[i].exp_hdr);
            checkOutput($sformatf("err vec %0d corr", i), corr_cnt, err_tbl[i].exp_corr);
            checkOutput($sformatf("err vec %0d crc", i), crc_cnt, err_tbl[i].exp_crc);
        end

        // Clear on the same cycle as a tlast beat and a crc pulse
        send_line(0, 3, 1'b0);
        begin
            stim_t s = '0;
            s.tvalid = 2'b01; s.tready = 2'b01; s.tlast = 2'b01;
            s.crc = 1'b1; s.clr = 1'b1;
            applyStimulus(s);
        end
        checkOutput("clear hdr_cnt", hdr_cnt, 32'd0);
        checkOutput("clear corr_cnt", corr_cnt, 32'd0);
        checkOutput("clear crc_cnt", crc_cnt, 32'd0);
        checkOutput("clear stat_valid", 32'(stat_valid), 32'd0);
        check_ch_clear(0, "clear ch0");
        check_ch_clear(1, "clear ch1");

        // Beats before the first SOF are ignored; then SOF with tlast
        send_line(0, 4, 1'b0);
        send_line(0, 6, 1'b0);
        checkOutput("pre-SOF max_px", max_px_ch[0], 32'd0);
        checkOutput("pre-SOF frame_cnt", frame_ch[0], 32'd0);
        beat(0, 1'b1, 1'b1);
        checkOutput("SOF+EOL min_px", min_px_ch[0], 32'd1);
        checkOutput("SOF+EOL max_px", max_px_ch[0], 32'd1);
        checkOutput("SOF+EOL stat_valid", 32'(stat_valid), 32'd0);
        beat(0, 1'b1, 1'b0);
        checkOutput("1-line frame min_ln", min_ln_ch[0], 32'd1);
        checkOutput("1-line frame max_ln", max_ln_ch[0], 32'd1);
        checkOutput("1-line frame frame_cnt", frame_ch[0], 32'd1);

        // Asynchronous reset mid-line
        beat(0, 1'b0, 1'b0);
        beat(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("async rst frame_cnt", frame_ch[0], 32'd0);
        checkOutput("async rst min_ln", min_ln_ch[0], 32'hffff);
        checkOutput("async rst max_px", max_px_ch[0], 32'd0);
        checkOutput("async rst stat_valid", 32'(stat_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(0, 1'b0, 1'b0);
        beat(0, 1'b0, 1'b1);
        checkOutput("post-rst line ignored", max_px_ch[0], 32'd0);
        send_frame(0, 2, 5, 0);
        beat(0, 1'b0, 1'b0);
        beat(0, 1'b0, 1'b0);
        beat(0, 1'b1, 1'b0);
        checkOutput("post-rst min_px", min_px_ch[0], 32'd5);
        checkOutput("post-rst max_px", max_px_ch[0], 32'd5);
        checkOutput("partial line min_ln", min_ln_ch[0], 32'd3);
        checkOutput("partial line max_ln", max_ln_ch[0], 32'd3);
        checkOutput("post-rst frame_cnt", frame_ch[0], 32'd1);
        checkOutput("post-rst stat_valid", 32'(stat_valid), 32'd1);
        check_ch_clear(1, "post-rst ch1");

        // 3-bit error counter saturation
        for (int i = 0; i < 7; i++) pulse_hdr();
        checkOutput("3b hdr at 7", 32'(hdr3), 32'd7);
        pulse_hdr();
        checkOutput("3b hdr holds after 8", 32'(hdr3), 32'd7);
        pulse_hdr();
        checkOutput("3b hdr holds after 9", 32'(hdr3), 32'd7);
        checkOutput("3b corr untouched", 32'(corr3), 32'd0);
        checkOutput("32b hdr after 9", hdr_cnt, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
